// File: rtl/serial_pattern_tx_if.sv
// Bus bundle for serial_pattern_tx: frame request/control inputs and serial outputs.
// Handshake: start is accepted on an enabled edge only while busy=0 and abort=0; done pulses when the last frame ends.
interface serial_pattern_tx_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  logic               ena;
  logic               start;
  logic               abort;
  logic [MAX_LEN-1:0] pattern;
  logic [4:0]         len;
  logic               repeat_en;
  logic               bit_out;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   frame_count;
  logic [1:0]         fsm_state;

  modport master (
    output ena, start, abort, pattern, len, repeat_en,
    input  bit_out, busy, done, frame_count, fsm_state
  );

  modport slave (
    input  ena, start, abort, pattern, len, repeat_en,
    output bit_out, busy, done, frame_count, fsm_state
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a latched 1..MAX_LEN bit pattern MSB-first,
// one-shot or repeated with a GAP-cycle zero gap between frames.
module serial_pattern_tx #(
  parameter int MAX_LEN = 8,
  parameter int GAP     = 2,
  parameter int CNT_W   = 8
) (
  input logic               clk,
  input logic               rst_n,
  serial_pattern_tx_if.slave bus
);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state;
  logic [MAX_LEN-1:0] pat_q;
  logic [4:0]         len_q;
  logic [IDX_W-1:0]   idx;
  logic [3:0]         gap_cnt;
  logic               bit_q;
  logic               busy_q;
  logic               done_q;
  logic [CNT_W-1:0]   count_q;

  logic [4:0]         len_eff;
  logic [IDX_W-1:0]   in_first;
  logic [IDX_W-1:0]   q_first;

  // Oversized lengths are clamped so the index never leaves the pattern.
  always_comb begin
    len_eff = bus.len;
    if (bus.len > 5'(MAX_LEN)) len_eff = 5'(MAX_LEN);
  end

  assign in_first = IDX_W'(len_eff - 5'd1);
  assign q_first  = IDX_W'(len_q - 5'd1);

  // rst_n is active-high in this codebase despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state   <= ST_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx     <= '0;
      gap_cnt <= '0;
      bit_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else if (bus.ena) begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            pat_q <= bus.pattern;
            len_q <= len_eff;
            if (len_eff == 5'd0) begin
              done_q <= 1'b1;
            end else begin
              state  <= ST_SHIFT;
              bit_q  <= bus.pattern[in_first];
              busy_q <= 1'b1;
              idx    <= in_first;
            end
          end
        end
        ST_SHIFT: begin
          if (bus.abort) begin
            state  <= ST_IDLE;
            bit_q  <= 1'b0;
            busy_q <= 1'b0;
          end else if (idx != '0) begin
            idx   <= idx - IDX_W'(1);
            bit_q <= pat_q[idx - IDX_W'(1)];
          end else begin
            count_q <= count_q + CNT_W'(1);
            if (bus.repeat_en) begin
              if (GAP > 0) begin
                state   <= ST_GAP;
                bit_q   <= 1'b0;
                gap_cnt <= 4'(GAP - 1);
              end else begin
                idx   <= q_first;
                bit_q <= pat_q[q_first];
              end
            end else begin
              state  <= ST_IDLE;
              bit_q  <= 1'b0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (bus.abort) begin
            state  <= ST_IDLE;
            bit_q  <= 1'b0;
            busy_q <= 1'b0;
          end else if (gap_cnt == 4'd0) begin
            state <= ST_SHIFT;
            idx   <= q_first;
            bit_q <= pat_q[q_first];
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          bit_q  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bit_out     = bit_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.frame_count = count_q;
  assign bus.fsm_state   = state;
endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Serial bit-pattern transmitter; the transmit end of the single-bit serial sequence interface that the team's sequence detector consumes.
- Shifts a programmable pattern, 1 to MAX_LEN bits, MSB-first onto one output bit, one bit per enabled clock.
- Supports one-shot or repeated frames with a fixed idle gap between repeats.
- Used to drive detector stimulus on-chip and as a pattern source on the dedicated output pins.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..16).
- GAP, 2, idle cycles between repeated frames (0..15); bit_out=0 during the gap.
- CNT_W, 8, width of frame_count.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-high (rst_n=1 resets).
- ena  input  1  clock enable; 0 freezes all state and outputs.
- start  input  1  frame request; sampled only in IDLE.
- abort  input  1  synchronous abort of the current frame or gap.
- pattern  input  MAX_LEN  bits to send; bit len-1 goes first.
- len  input  5  pattern length in bits.
- repeat_en  input  1  1 = re-send after GAP; sampled at the end of each frame.
- bit_out  output  1  serial data, registered.
- busy  output  1  high in SHIFT and GAP.
- done  output  1  one-cycle pulse when the last frame completes.
- frame_count  output  CNT_W  completed frames since reset; wraps.

Behaviour:
- Reset (asynchronous, rst_n=1):
  - state=IDLE.
  - bit_out=0, busy=0, done=0, frame_count=0.
  - The latched pattern, length and bit index are all cleared.
- ena=0: no state, counter or output changes. done, if high, stays high until the next enabled edge.
- The FSM has three states: IDLE, SHIFT and GAP. All transitions below occur on enabled edges only.
- IDLE:
  - On start=1, pattern and len are latched and len is clamped to MAX_LEN if larger.
  - len=0: stay in IDLE, pulse done, frame_count unchanged.
  - len>0: go to SHIFT, bit_out<=pattern[len-1], busy<=1, idx<=len-1.
- SHIFT:
  - Each edge with idx>0: idx<=idx-1 and bit_out<=latched[idx-1].
  - Each bit is held exactly one enabled cycle, so latency is 1 cycle from start acceptance to the first bit.
- End of frame (edge with idx==0 in SHIFT): frame_count<=frame_count+1 (mod 2^CNT_W). Then:
  - repeat_en=1, GAP>0: go to GAP, bit_out<=0, gap counter<=GAP-1.
  - repeat_en=1, GAP=0: restart SHIFT directly with the first bit of the latched pattern (no idle bit).
  - repeat_en=0: go to IDLE, bit_out<=0, busy<=0, done<=1 for one cycle.
- GAP:
  - bit_out=0. When the gap counter reaches 0, go to SHIFT with the first latched bit.
  - repeat_en is not re-sampled during GAP.
- Repeated frames reuse the latched pattern and len. pattern and len changes while busy are ignored.
- start while busy is ignored (no queueing).
- abort=1 in SHIFT or GAP:
  - Next state=IDLE, bit_out=0, busy=0.
  - No done pulse and no frame_count increment.
  - abort has priority over end-of-frame.
- abort in IDLE has no effect, and abort has priority over start in the same cycle.
- done is never high in the same cycle as busy=1.

Test Plan:
- Single frame: pattern=8'h04, len=3, repeat_en=0, start for 1 cycle.
  - Required: bit_out=1,0,0 on the 3 cycles after start.
  - The next cycle has done=1, busy=0, bit_out=0, frame_count=1.
- Repeat with GAP=2: same pattern, repeat_en=1.
  - Required stream: 1,0,0,0,0,1,0,0,0,0,...
  - Drop repeat_en mid-frame 3: the frame completes, done pulses after it, and frame_count=3.
- ena gating: drop ena for 2 cycles while the second bit is on bit_out.
  - Required: that bit is held 3 cycles total; the remaining sequence and the done timing shift by exactly 2.
- Boundaries:
  - len=0: done next cycle, busy never asserted, frame_count unchanged.
  - len=20 with pattern=8'hA5: 8 bits 1,0,1,0,0,1,0,1 are sent.
  - Run 256 frames: frame_count wraps to 0.
- Start, abort and reset conflicts:
  - start pulsed while busy: ignored, stream unchanged.
  - abort on the last bit: IDLE next cycle, no done, count unchanged.
  - abort with start in IDLE: stays IDLE.
  - rst_n=1 asynchronously mid-frame: all outputs 0 immediately. After release, a fresh start transmits normally.
